// File: rtl/icache_refill_ctrl.sv
// Miss handler for the direct-mapped instruction cache: stalls the core on a miss,
// fetches the word from backing memory, writes it into the cache, then re-checks the hit.
module icache_refill_ctrl #(
    parameter int DATAW   = 32,
    parameter int HIT_LAT = 3,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [DATAW-1:0] addr_i,
    input  logic             hit_i,
    output logic [DATAW-1:0] rd_addr_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             cache_we_o,
    output logic [DATAW-1:0] cache_addw_o,
    output logic [DATAW-1:0] cache_dataw_o,
    output logic             mem_req_o,
    output logic [DATAW-1:0] mem_addr_o,
    input  logic             mem_ack_i,
    input  logic [DATAW-1:0] mem_rdata_i,
    output logic             err_o,
    output logic [15:0]      miss_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MREQ,
        S_FILL,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [3:0] LAT_INIT = 4'(HIT_LAT - 1);
    // Last counter value before the timeout fires; an ack in that cycle still wins.
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_e           state;
    logic [3:0]       lat_cnt;
    logic [7:0]       to_cnt;
    logic             refilled;
    logic [DATAW-1:0] addr_q;
    logic [DATAW-1:0] data_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign rd_addr_o     = addr_q;
    assign cache_addw_o  = addr_q;
    assign cache_dataw_o = data_q;
    assign mem_addr_o    = {addr_q[DATAW-1:2], 2'b00};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            to_cnt     <= '0;
            refilled   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            stall_o    <= 1'b0;
            done_o     <= 1'b0;
            cache_we_o <= 1'b0;
            mem_req_o  <= 1'b0;
            err_o      <= 1'b0;
            miss_cnt_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_i && !err_o) begin
                        addr_q  <= addr_i;
                        lat_cnt <= LAT_INIT;
                        stall_o <= 1'b1;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (hit_i) begin
                        stall_o <= 1'b0;
                        done_o  <= 1'b1;
                        state   <= S_DONE;
                    end else if (!refilled) begin
                        mem_req_o <= 1'b1;
                        to_cnt    <= '0;
                        state     <= S_MREQ;
                    end else begin
                        // The line was just written yet still misses: the cache is broken.
                        err_o <= 1'b1;
                        state <= S_ERR;
                    end
                end
                S_MREQ: begin
                    if (mem_ack_i) begin
                        data_q     <= mem_rdata_i;
                        mem_req_o  <= 1'b0;
                        cache_we_o <= 1'b1;
                        state      <= S_FILL;
                    end else if (to_cnt == TO_LAST) begin
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_FILL: begin
                    cache_we_o <= 1'b0;
                    refilled   <= 1'b1;
                    miss_cnt_o <= sat_inc16(miss_cnt_o);
                    lat_cnt    <= LAT_INIT;
                    state      <= S_LOOKUP;
                end
                S_DONE: begin
                    done_o   <= 1'b0;
                    refilled <= 1'b0;
                    state    <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized bench for icache_refill_ctrl: a transaction-level model predicts hit/miss,
// latencies, memory and cache traffic, and the refill count for each request.
module tb_icache_refill_ctrl;

    localparam int DATAW   = 32;
    localparam int HIT_LAT = 3;
    localparam int TIMEOUT = 255;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_i = 1'b0;
    logic        hit_i = 1'b0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] rd_addr_o, cache_addw_o, cache_dataw_o, mem_addr_o;
    logic        stall_o, done_o, cache_we_o, mem_req_o, err_o;
    logic [15:0] miss_cnt_o;

    icache_refill_ctrl #(.DATAW(DATAW), .HIT_LAT(HIT_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .hit_i(hit_i),
        .rd_addr_o(rd_addr_o), .stall_o(stall_o), .done_o(done_o),
        .cache_we_o(cache_we_o), .cache_addw_o(cache_addw_o), .cache_dataw_o(cache_dataw_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .err_o(err_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Cache emulation that produces hit_i from the DUT's own writes.
    bit          env_vld [1024];
    logic [19:0] env_tag [1024];

    // Reference model: resident word address per cache index, and expected refill count.
    logic [31:0] mdl_line [int];
    logic [15:0] mdl_misses = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return 32'({stall_o, done_o, cache_we_o, mem_req_o, err_o});
    endfunction

    function automatic bit mdl_hit(input logic [31:0] a);
        int idx = int'(a[11:2]);
        return mdl_line.exists(idx) && (mdl_line[idx][31:2] == a[31:2]);
    endfunction

    function automatic logic [31:0] rand_addr();
        return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    task automatic env_step(input bit fmiss);
        if (cache_we_o) begin
            env_vld[cache_addw_o[11:2]] = 1'b1;
            env_tag[cache_addw_o[11:2]] = cache_addw_o[31:12];
        end
        hit_i = !fmiss && env_vld[rd_addr_o[11:2]] && (env_tag[rd_addr_o[11:2]] == rd_addr_o[31:12]);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_i = 1'b0; mem_ack_i = 1'b0; hit_i = 1'b0;
        mdl_misses = '0;
        @(negedge clk_i);
        check_eq("rst_ctl", ctl(), 32'd0);
        check_eq("rst_cnt", 32'(miss_cnt_o), 32'd0);
        check_eq("rst_rd_addr", rd_addr_o, 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'd0);
        check_eq("rst_addw", cache_addw_o, 32'd0);
        check_eq("rst_dataw", cache_dataw_o, 32'd0);
        rst_ni = 1'b1;
    endtask

    task automatic err_tail();
        for (int k = 0; k < 4; k++) begin
            req_i = 1'b1; addr_i = $urandom;
            @(negedge clk_i);
            env_step(1'b0);
            check_eq("err_hold", ctl(), 32'b10001);
        end
        check_eq("err_cnt", 32'(miss_cnt_o), 32'(mdl_misses));
        req_i = 1'b0;
    endtask

    // d = MREQ cycle in which memory acks (0 = never). Cycle 1 is the first cycle after accept.
    task automatic txn(input logic [31:0] a, input int d, input logic [31:0] rdata,
                       input bit fmiss, input bit chain, input logic [31:0] next_a);
        bit hit, acked, to_err;
        int mreq_n, fill_c, end_c;
        logic [31:0] exp_ctl;
        logic [31:0] a_word;
        hit    = mdl_hit(a);
        acked  = !hit && d >= 1 && d <= TIMEOUT;
        mreq_n = hit ? 0 : (acked ? d : TIMEOUT);
        fill_c = HIT_LAT + mreq_n + 1;
        to_err = !hit && (!acked || fmiss);
        if (hit)        end_c = HIT_LAT + 1;
        else if (!acked) end_c = HIT_LAT + TIMEOUT + 1;
        else            end_c = 2 * HIT_LAT + d + 2;
        a_word = {a[31:2], 2'b00};
        req_i = 1'b1; addr_i = a;
        for (int k = 1; k <= end_c; k++) begin
            @(negedge clk_i);
            env_step(fmiss);
            exp_ctl = 32'({(k != end_c || to_err), (k == end_c && !to_err), (acked && k == fill_c),
                           (!hit && k > HIT_LAT && k <= HIT_LAT + mreq_n), (k == end_c && to_err)});
            check_eq($sformatf("ctl@%0d", k), ctl(), exp_ctl);
            if (k == 1) check_eq("rd_addr", rd_addr_o, a);
            if (!hit && k == HIT_LAT + 1) check_eq("mem_addr", mem_addr_o, a_word);
            if (!hit && k == HIT_LAT + mreq_n) check_eq("mem_addr_hold", mem_addr_o, a_word);
            if (acked && k == fill_c) begin
                check_eq("fill_addw", cache_addw_o, a);
                check_eq("fill_dataw", cache_dataw_o, rdata);
            end
            req_i = 1'($urandom_range(0, 1));
            addr_i = $urandom;
            mem_rdata_i = $urandom;
            mem_ack_i = acked && (k == HIT_LAT + d);
            if (mem_ack_i) mem_rdata_i = rdata;
        end
        mem_ack_i = 1'b0;
        if (acked) begin
            mdl_line[int'(a[11:2])] = a;
            if (mdl_misses != 16'hFFFF) mdl_misses++;
        end
        check_eq("miss_cnt", 32'(miss_cnt_o), 32'(mdl_misses));
        if (to_err) begin
            err_tail();
        end else begin
            req_i = chain; addr_i = next_a;
            @(negedge clk_i);
            env_step(1'b0);
            check_eq("idle", ctl(), 32'd0);
        end
    endtask

    task automatic reset_in_mreq(input logic [31:0] a);
        req_i = 1'b1; addr_i = a;
        for (int k = 1; k <= HIT_LAT + 3; k++) begin
            @(negedge clk_i);
            env_step(1'b0);
            req_i = 1'b0; mem_ack_i = 1'b0; addr_i = $urandom;
        end
        check_eq("pre_rst_mreq", 32'(mem_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        mdl_misses = '0;
        check_eq("rst_mreq_ctl", ctl(), 32'd0);
        check_eq("rst_mreq_addr", mem_addr_o, 32'd0);
        check_eq("rst_mreq_cnt", 32'(miss_cnt_o), 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = $urandom;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            env_step(1'b0);
            check_eq("stale_ack", ctl(), 32'd0);
            mem_ack_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a, na;
        bit ch;
        do_reset();

        env_vld[16] = 1'b1; env_tag[16] = 20'h0;
        mdl_line[16] = 32'h0000_0040;
        txn(32'h0000_0040, 1, 32'h0, 1'b0, 1'b0, 32'h0);

        txn(32'h0001_2344, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);

        txn(32'h0000_5008, 3, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_6008);
        txn(32'h0000_6008, 2, 32'h2222_2222, 1'b0, 1'b0, 32'h0);

        a = rand_addr();
        for (int t = 0; t < 20; t++) begin
            ch = 1'($urandom_range(0, 1));
            na = rand_addr();
            txn(a, int'($urandom_range(1, 6)), $urandom, 1'b0, ch, na);
            a = na;
        end

        txn(32'h00AB_C100, TIMEOUT, $urandom, 1'b0, 1'b0, 32'h0);

        txn(32'h0077_7010, 2, $urandom, 1'b1, 1'b0, 32'h0);
        do_reset();
        txn(32'h0077_7010, 2, $urandom, 1'b0, 1'b0, 32'h0);

        txn(32'h0033_3020, 0, 32'h0, 1'b0, 1'b0, 32'h0);
        do_reset();

        reset_in_mreq(32'h0044_4030);
        txn(32'h0044_4030, 2, $urandom, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
